hamming_stream_encoder: RTL and testbench
=========================================

// Module: hamming_stream_encoder
// PURPOSE
//  SECDED(8,4) stream encoder; the transmit-side counterpart of hamming_decoder.
//  Accepts bytes over a valid/ready handshake and splits each into two nibbles (low first).
//  Emits two 8-bit codewords with optional per-codeword fault injection, for driving the decoder on-chip.
//  Codeword layout {c_all,d3,d2,d1,c2,d0,c1,c0}: c0=d0^d1^d3, c1=d0^d2^d3, c2=d1^d2^d3, c_all=^bits[6:0].
// PARAMETERS
//  CNT_W      16  width of emitted-codeword counter (wraps)
//  INJ_CNT_W  8   width of injected-codeword counter (saturates)
// PORTS
//  clk        in   1          clock, single domain, rising edge
//  rst_n      in   1          reset, asynchronous assert, active-low
//  in_valid   in   1          byte offered
//  in_ready   out  1          byte accepted when in_valid&in_ready at clk rise
//  in_data    in   8          data byte; [3:0] sent first, [7:4] second
//  inj_sel    in   2          sampled with byte: 00 none, 01 low cw, 10 high cw, 11 both
//  inj_mask   in   8          sampled with byte; XORed onto each selected codeword
//  out_valid  out  1          codeword valid
//  out_ready  in   1          sink accepts when out_valid&out_ready at clk rise
//  out_code   out  8          codeword (after injection)
//  out_last   out  1          1 on the high-nibble codeword of a byte
//  cw_count   out  CNT_W      codewords accepted by sink, modulo 2^CNT_W
//  inj_count  out  INJ_CNT_W  accepted codewords with nonzero applied mask, saturating
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; out_valid=0, out_code=0, out_last=0, in_ready=0 while in reset;
//    byte/mask/sel regs=0, both counters=0. In-flight nibbles are dropped, never emitted after reset.
//  - FSM states IDLE, LO, HI (registered):
//    IDLE: in_valid -> capture in_data/inj_sel/inj_mask, go LO.
//    LO: out_ready -> HI; else hold.
//    HI: out_ready&in_valid -> capture new byte, go LO; out_ready&!in_valid -> IDLE; else hold.
//  - in_ready = (state==IDLE) | (state==HI & out_ready); the only combinational in->out path is out_ready->in_ready.
//  - out_valid = (state!=IDLE); out_last = (state==HI).
//  - out_code = enc(nibble) ^ (sel bit ? mask : 0); all from registers, no path from in_data.
//    In IDLE, out_code=0.
//  - Latency: byte accepted at edge N -> low cw valid after edge N; high cw after first out_ready edge.
//  - Throughput: with out_ready=1 and in_valid=1, one codeword per cycle, no bubbles.
//  - Stability: while out_valid&!out_ready, out_code/out_last are held; in_valid/in_data changes are ignored.
//  - Counters update only on out_valid&out_ready. cw_count: +1 with wrap all-ones->0.
//    inj_count: +1 if applied mask!=0, holds at all-ones. inj_mask=0 with inj_sel!=0 does not count.
//  - Overall parity even over all 8 bits; hamming_decoder reports syndrome 0, flag 00 for clean codewords.
// STRUCTURE
//  - hamming_pkg: bit-position localparams (C0=0,C1=1,D0=2,C2=3,D1=4,D2=5,D3=6,CALL=7),
//    FSM state encoding, function hamming_enc84(nibble)->codeword shared with the decoder.
//  - Sub-module hamming_enc84: pure combinational nibble->codeword; top instantiates one,
//    muxing the nibble by state.
// TESTING
//  - Table: nibbles 0x0,0x1,0xB,0xF -> 0x00,0x87,0x55,0xFF; each also round-trips
//    through hamming_decoder with flag 00.
//  - Byte 0xB1, sel=00, out_ready=1 -> 0x87 (last=0) then 0x55 (last=1); cw_count=2, inj_count=0.
//  - Byte 0x0F, sel=10, mask=0x04 -> 0xFF then 0x04; decoder flags single error (01), corrects to 0x00;
//    inj_count=1. Mask 0x06 -> decoder flag 10.
//  - Backpressure: out_ready=0 for 3 cycles in LO -> out_code held 0x87, in_ready=0. Then stream
//    4 bytes with out_ready=1 -> 8 consecutive codewords, in_ready high every 2nd cycle.
//  - Reset mid-byte: rst_n low while in HI -> out_valid=0 immediately (async), counters 0;
//    after release, no stale high-nibble codeword appears.
//  - Width boundaries (CNT_W=4, INJ_CNT_W=2): 17 codewords -> cw_count=1;
//    5 injected codewords -> inj_count=3.

Source files
------------

// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hamming_pkg
// Purpose  : Shared definitions for the SECDED(8,4) encoder/decoder pair:
//            codeword bit positions, stream-encoder FSM encoding and the
//            nibble->codeword encode function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    // Codeword layout {c_all,d3,d2,d1,c2,d0,c1,c0}
    localparam int C0   = 0;
    localparam int C1   = 1;
    localparam int D0   = 2;
    localparam int C2   = 3;
    localparam int D1   = 4;
    localparam int D2   = 5;
    localparam int D3   = 6;
    localparam int CALL = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    // Overall parity bit makes the whole 8-bit codeword even-parity.
    function automatic logic [7:0] hamming_enc84(input logic [3:0] nib);
        logic [7:0] cw;
        cw       = '0;
        cw[D0]   = nib[0];
        cw[D1]   = nib[1];
        cw[D2]   = nib[2];
        cw[D3]   = nib[3];
        cw[C0]   = nib[0] ^ nib[1] ^ nib[3];
        cw[C1]   = nib[0] ^ nib[2] ^ nib[3];
        cw[C2]   = nib[1] ^ nib[2] ^ nib[3];
        cw[CALL] = ^cw[6:0];
        return cw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_stream_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : hamming_stream_encoder_if
// Purpose  : Byte-in / codeword-out handshake bundle of the stream encoder.
// Ports    : in_valid/in_ready/in_data/inj_sel/inj_mask (byte side),
//            out_valid/out_ready/out_code/out_last (codeword side).
//            slave  = encoder view, master = source/sink environment view.
// Revision : 1.0 - initial release
// ============================================================================
interface hamming_stream_encoder_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] inj_sel;
    logic [7:0] inj_mask;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_code;
    logic       out_last;

    modport slave (
        input  in_valid, in_data, inj_sel, inj_mask, out_ready,
        output in_ready, out_valid, out_code, out_last
    );

    modport master (
        output in_valid, in_data, inj_sel, inj_mask, out_ready,
        input  in_ready, out_valid, out_code, out_last
    );
endinterface
`default_nettype wire

// File: rtl/hamming_enc84.sv
`default_nettype none
// ============================================================================
// Module   : hamming_enc84
// Purpose  : Combinational SECDED(8,4) nibble encoder.
// Ports    : nibble (in, 4)  - data nibble
//            code   (out, 8) - codeword {c_all,d3,d2,d1,c2,d0,c1,c0}
// Revision : 1.0 - initial release
// ============================================================================
module hamming_enc84
    import hamming_pkg::*;
(
    input  wire logic [3:0] nibble,
    output logic      [7:0] code
);
    assign code = hamming_enc84(nibble);
endmodule
`default_nettype wire

// File: rtl/hamming_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : hamming_stream_encoder
// Purpose  : Splits each accepted byte into two nibbles (low first) and emits
//            their SECDED(8,4) codewords, with optional per-codeword XOR fault
//            injection for exercising the decoder.
// Ports    : clk, rst_n (async active-low)
//            bus       - hamming_stream_encoder_if.slave handshake bundle
//            cw_count  (out, CNT_W)     - codewords accepted by sink, wraps
//            inj_count (out, INJ_CNT_W) - accepted injected codewords, saturates
// Revision : 1.0 - initial release
// ============================================================================
module hamming_stream_encoder
    import hamming_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int INJ_CNT_W = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    hamming_stream_encoder_if.slave   bus,
    output logic [CNT_W-1:0]          cw_count,
    output logic [INJ_CNT_W-1:0]      inj_count
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_byte;
    logic [1:0]             r_sel;
    logic [7:0]             r_mask;
    logic [CNT_W-1:0]       r_cw_count;
    logic [INJ_CNT_W-1:0]   r_inj_count;

    logic                   w_in_ready;
    logic                   w_capture;
    logic                   w_fire;
    logic [3:0]             w_nibble;
    logic [7:0]             w_code_raw;
    logic                   w_apply;
    logic [7:0]             w_mask_applied;

    // Gating with rst_n keeps in_ready low while reset is asserted even
    // though the state register already sits in IDLE.
    assign w_in_ready = rst_n & ((r_state == ST_IDLE) ||
                                 ((r_state == ST_HI) && bus.out_ready));
    assign w_capture  = bus.in_valid & w_in_ready;
    assign w_fire     = (r_state != ST_IDLE) & bus.out_ready;

    assign w_nibble   = (r_state == ST_HI) ? r_byte[7:4] : r_byte[3:0];

    hamming_enc84 u_enc (
        .nibble (w_nibble),
        .code   (w_code_raw)
    );

    assign w_apply        = ((r_state == ST_LO) & r_sel[0]) |
                            ((r_state == ST_HI) & r_sel[1]);
    assign w_mask_applied = w_apply ? r_mask : 8'h00;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state != ST_IDLE);
    assign bus.out_last  = (r_state == ST_HI);
    assign bus.out_code  = (r_state == ST_IDLE) ? 8'h00 : (w_code_raw ^ w_mask_applied);
    assign cw_count      = r_cw_count;
    assign inj_count     = r_inj_count;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_state_nxt = ST_LO;
            ST_LO:   if (bus.out_ready) w_state_nxt = ST_HI;
            ST_HI: begin
                if (bus.out_ready) w_state_nxt = bus.in_valid ? ST_LO : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte <= 8'h00;
            r_sel  <= 2'b00;
            r_mask <= 8'h00;
        end else if (w_capture) begin
            r_byte <= bus.in_data;
            r_sel  <= bus.inj_sel;
            r_mask <= bus.inj_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cw_count  <= '0;
            r_inj_count <= '0;
        end else if (w_fire) begin
            r_cw_count <= r_cw_count + 1'b1;
            if ((w_mask_applied != 8'h00) && (r_inj_count != '1)) begin
                r_inj_count <= r_inj_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hamming_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_stream_encoder
// Purpose  : Self-checking bench for hamming_stream_encoder (CNT_W=4,
//            INJ_CNT_W=2) with a reference SECDED decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_stream_encoder;

    localparam int CNT_W     = 4;
    localparam int INJ_CNT_W = 2;

    logic                 clk;
    logic                 rst_n;
    logic [CNT_W-1:0]     cw_count;
    logic [INJ_CNT_W-1:0] inj_count;

    hamming_stream_encoder_if bus_if ();

    hamming_stream_encoder #(
        .CNT_W     (CNT_W),
        .INJ_CNT_W (INJ_CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .cw_count  (cw_count),
        .inj_count (inj_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] sel;
        logic [7:0] mask;
        logic [7:0] exp_lo;
        logic [7:0] exp_hi;
        logic [1:0] flag_lo;
        logic [1:0] flag_hi;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decoder: flag 00 clean, 01 single (corrected), 10 double.
    function automatic void ref_dec(input logic [7:0] cw, output logic [1:0] flag,
                                    output logic [3:0] data);
        logic [7:0] c;
        logic [2:0] s;
        logic       p;
        c = cw;
        s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
        s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
        s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
        p    = ^c;
        if (p) begin
            flag = 2'b01;
            if (s != 3'd0) c[s - 3'd1] = ~c[s - 3'd1];
            else           c[7] = ~c[7];
        end else if (s != 3'd0) begin
            flag = 2'b10;
        end else begin
            flag = 2'b00;
        end
        data = {c[6], c[5], c[4], c[2]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Sends one byte with out_ready held high and returns both codewords.
    task automatic send_byte(input logic [7:0] d, input logic [1:0] s, input logic [7:0] m,
                             output logic [7:0] c0, output logic l0,
                             output logic [7:0] c1, output logic l1);
        int n;
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = d;
        bus_if.inj_sel   = s;
        bus_if.inj_mask  = m;
        bus_if.out_ready = 1'b1;
        n = 0;
        while (!bus_if.in_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        step();
        bus_if.in_valid = 1'b0;
        #0;
        c0 = bus_if.out_code;
        l0 = bus_if.out_last;
        step();
        c1 = bus_if.out_code;
        l1 = bus_if.out_last;
        step();
    endtask

    initial begin
        logic [7:0] c0, c1;
        logic       l0, l1;
        logic [1:0] flg;
        logic [3:0] dat;
        logic [7:0] stream_exp [8];
        logic [7:0] stream_bytes [4];

        vecs[0] = '{8'h00, 2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00};
        vecs[1] = '{8'h11, 2'b00, 8'h00, 8'h87, 8'h87, 2'b00, 2'b00};
        vecs[2] = '{8'hBB, 2'b00, 8'h00, 8'h55, 8'h55, 2'b00, 2'b00};
        vecs[3] = '{8'hFF, 2'b00, 8'h00, 8'hFF, 8'hFF, 2'b00, 2'b00};
        vecs[4] = '{8'hB1, 2'b00, 8'h00, 8'h87, 8'h55, 2'b00, 2'b00};
        vecs[5] = '{8'h0F, 2'b10, 8'h04, 8'hFF, 8'h04, 2'b00, 2'b01};
        vecs[6] = '{8'h0F, 2'b10, 8'h06, 8'hFF, 8'h06, 2'b00, 2'b10};
        vecs[7] = '{8'h0F, 2'b11, 8'h00, 8'hFF, 8'h00, 2'b00, 2'b00};
        vecs[8] = '{8'hF0, 2'b01, 8'h80, 8'h80, 8'hFF, 2'b01, 2'b00};

        stream_bytes[0] = 8'h11; stream_bytes[1] = 8'hB0;
        stream_bytes[2] = 8'hFB; stream_bytes[3] = 8'h0F;
        stream_exp[0] = 8'h87; stream_exp[1] = 8'h87;
        stream_exp[2] = 8'h00; stream_exp[3] = 8'h55;
        stream_exp[4] = 8'h55; stream_exp[5] = 8'hFF;
        stream_exp[6] = 8'hFF; stream_exp[7] = 8'h00;

        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 8'h00;
        bus_if.inj_sel   = 2'b00;
        bus_if.inj_mask  = 8'h00;
        bus_if.out_ready = 1'b0;
        #12;
        check("reset_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("reset_in_ready",  {31'd0, bus_if.in_ready},  32'd0);
        check("reset_out_code",  {24'd0, bus_if.out_code},  32'd0);
        check("reset_out_last",  {31'd0, bus_if.out_last},  32'd0);
        check("reset_cw_count",  {28'd0, cw_count},         32'd0);
        check("reset_inj_count", {30'd0, inj_count},        32'd0);
        do_reset();

        // Single byte 0xB1, clean
        send_byte(8'hB1, 2'b00, 8'h00, c0, l0, c1, l1);
        check("b1_lo_code", {24'd0, c0}, 32'h87);
        check("b1_lo_last", {31'd0, l0}, 32'd0);
        check("b1_hi_code", {24'd0, c1}, 32'h55);
        check("b1_hi_last", {31'd0, l1}, 32'd1);
        check("b1_cw_count",  {28'd0, cw_count},  32'd2);
        check("b1_inj_count", {30'd0, inj_count}, 32'd0);
        check("b1_idle_valid", {31'd0, bus_if.out_valid}, 32'd0);

        // Table of vectors, each codeword round-tripped through the reference decoder
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_byte(vecs[i].data, vecs[i].sel, vecs[i].mask, c0, l0, c1, l1);
            check($sformatf("vec%0d_lo_code", i), {24'd0, c0}, {24'd0, vecs[i].exp_lo});
            check($sformatf("vec%0d_hi_code", i), {24'd0, c1}, {24'd0, vecs[i].exp_hi});
            check($sformatf("vec%0d_lo_last", i), {31'd0, l0}, 32'd0);
            check($sformatf("vec%0d_hi_last", i), {31'd0, l1}, 32'd1);
            ref_dec(c0, flg, dat);
            check($sformatf("vec%0d_lo_flag", i), {30'd0, flg}, {30'd0, vecs[i].flag_lo});
            if (vecs[i].flag_lo != 2'b10)
                check($sformatf("vec%0d_lo_data", i), {28'd0, dat}, {28'd0, vecs[i].data[3:0]});
            ref_dec(c1, flg, dat);
            check($sformatf("vec%0d_hi_flag", i), {30'd0, flg}, {30'd0, vecs[i].flag_hi});
            if (vecs[i].flag_hi != 2'b10)
                check($sformatf("vec%0d_hi_data", i), {28'd0, dat}, {28'd0, vecs[i].data[7:4]});
        end
        // 18 codewords wrap a 4-bit counter to 2; three injected saturate at 3
        check("tbl_cw_count",  {28'd0, cw_count},  32'd2);
        check("tbl_inj_count", {30'd0, inj_count}, 32'd3);

        // Backpressure in LO, then a back-to-back stream
        do_reset();
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = stream_bytes[0];
        bus_if.inj_sel   = 2'b00;
        bus_if.inj_mask  = 8'h00;
        bus_if.out_ready = 1'b0;
        step();
        bus_if.in_data = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d_code", k),  {24'd0, bus_if.out_code},  32'h87);
            check($sformatf("bp%0d_ready", k), {31'd0, bus_if.in_ready},  32'd0);
            check($sformatf("bp%0d_valid", k), {31'd0, bus_if.out_valid}, 32'd1);
            check($sformatf("bp%0d_last", k),  {31'd0, bus_if.out_last},  32'd0);
            step();
        end
        bus_if.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 1) begin
                if (k < 7) bus_if.in_data = stream_bytes[(k + 1) / 2];
                bus_if.in_valid = (k < 7);
            end
            #0;
            check($sformatf("st%0d_valid", k), {31'd0, bus_if.out_valid}, 32'd1);
            check($sformatf("st%0d_code", k),  {24'd0, bus_if.out_code},  {24'd0, stream_exp[k]});
            check($sformatf("st%0d_last", k),  {31'd0, bus_if.out_last},  (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("st%0d_ready", k), {31'd0, bus_if.in_ready},  (k % 2 == 1) ? 32'd1 : 32'd0);
            step();
        end
        bus_if.in_valid = 1'b0;
        check("st_end_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("st_cw_count",  {28'd0, cw_count},         32'd8);

        // Asynchronous reset while in HI
        do_reset();
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = 8'hB1;
        bus_if.inj_sel   = 2'b00;
        bus_if.out_ready = 1'b0;
        step();
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        check("mid_last_before", {31'd0, bus_if.out_last}, 32'd1);
        check("mid_cw_before",   {28'd0, cw_count},        32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, bus_if.in_ready},  32'd0);
        check("mid_rst_cw",    {28'd0, cw_count},         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("post_rst%0d_valid", k), {31'd0, bus_if.out_valid}, 32'd0);
        end
        check("post_rst_cw", {28'd0, cw_count}, 32'd0);

        // Counter width boundaries
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(8'h5A, 2'b00, 8'h00, c0, l0, c1, l1);
        check("wrap16_cw", {28'd0, cw_count}, 32'd0);
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = 8'h12;
        bus_if.out_ready = 1'b1;
        step();
        bus_if.in_valid = 1'b0;
        step();
        check("wrap17_cw", {28'd0, cw_count}, 32'd1);
        step();
        do_reset();
        send_byte(8'h33, 2'b11, 8'h01, c0, l0, c1, l1);
        send_byte(8'h33, 2'b11, 8'h01, c0, l0, c1, l1);
        send_byte(8'h33, 2'b01, 8'h01, c0, l0, c1, l1);
        check("sat5_inj", {30'd0, inj_count}, 32'd3);
        check("sat5_cw",  {28'd0, cw_count},  32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
